// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// This stage drives load/store strobes to the dcache and waits for the one-cycle dhit
// acknowledge. It then selects the writeback datum and latches the result into MEM/WB.
// Optional build macro MEM_STALL_CNT_EN adds a saturating stall-cycle counter (stall_cnt).
module mem_wb_stage #(
   parameter int WORD_W = 32,
   parameter int REG_AW = 5
`ifdef MEM_STALL_CNT_EN
   ,
   parameter int SCNT_W = 32
`endif
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] pipe_npc_i,
   input  logic [WORD_W-1:0] aluout_i,
   input  logic [WORD_W-1:0] rdat2_i,
   input  logic [1:0]        rfInSel_i,
   input  logic [REG_AW-1:0] wsel_i,
   input  logic              rfWEN_i,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic              halt_i,
   input  logic              wb_en,
   input  logic              flush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] pipe_npc_o,
   output logic [WORD_W-1:0] wdat_o,
   output logic [REG_AW-1:0] wsel_o,
   output logic              rfWEN_o,
   output logic              halt_o
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [SCNT_W-1:0] stall_cnt
`endif
);

   // IDLE: no access in flight; BUSY: waiting for dhit; HELD: load data parked in lbuf
   typedef enum logic [1:0] {IDLE, BUSY, HELD} state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   lbuf_q, lbuf_d;
   logic [WORD_W-1:0]   instr_q, instr_d;
   logic [WORD_W-1:0]   npc_q, npc_d;
   logic [WORD_W-1:0]   wdat_q, wdat_d;
   logic [REG_AW-1:0]   wsel_q, wsel_d;
   logic                rf_wen_q, rf_wen_d;
   logic                halt_q, halt_d;

   logic                memop;
   logic                req;
   logic [WORD_W-1:0]   load_data;
   logic [WORD_W-1:0]   wb_data;

   assign dmemaddr  = aluout_i;
   assign dmemstore = rdat2_i;

   // Request strobes and stall: combinational so the access starts in its first cycle.
   // The request is gated by nRST so it drops the instant reset is asserted.
   always_comb begin
      memop     = dREN_i | dWEN_i;
      req       = memop && (state_q != HELD) && nRST;
      dmemWEN   = dWEN_i && req;
      dmemREN   = dREN_i && !dWEN_i && req;
      mem_stall = (req && !dhit) || !wb_en;
   end

   // Access FSM next state and load-buffer capture.
   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      lbuf_d  = lbuf_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            // A hit in the request's first cycle counts like a hit in BUSY. A hit that
            // cannot advance parks the data, so the access is never issued twice.
            IDLE, BUSY: begin
               if (!memop) begin
                  state_d = IDLE;
               end else if (dhit) begin
                  if (wb_en) begin
                     state_d = IDLE;
                  end else begin
                     state_d = HELD;
                     lbuf_d  = dmemload;
                  end
               end else begin
                  state_d = BUSY;
               end
            end
            HELD: begin
               if (wb_en) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Writeback select and MEM/WB next contents: advance, bubble, hold or flush.
   always_comb begin
      load_data = (state_q == HELD) ? lbuf_q : dmemload;
      case (rfInSel_i)
         2'd1:    wb_data = load_data;
         2'd2:    wb_data = pipe_npc_i;
         default: wb_data = aluout_i;
      endcase

      instr_d  = instr_q;
      npc_d    = npc_q;
      wdat_d   = wdat_q;
      wsel_d   = wsel_q;
      rf_wen_d = rf_wen_q;
      halt_d   = halt_q;

      if (flush) begin
         // halt stays sticky across a flush
         instr_d  = '0;
         npc_d    = '0;
         wdat_d   = '0;
         wsel_d   = '0;
         rf_wen_d = 1'b0;
      end else if (wb_en && !mem_stall) begin
         instr_d  = instr_i;
         npc_d    = pipe_npc_i;
         wdat_d   = wb_data;
         wsel_d   = wsel_i;
         rf_wen_d = rfWEN_i && (wsel_i != '0);
         halt_d   = halt_q | halt_i;
      end else if (wb_en) begin
         // memory stall: insert a bubble so the stalled instruction retires only once
         instr_d  = '0;
         rf_wen_d = 1'b0;
      end
   end

   // State and MEM/WB registers.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         lbuf_q   <= '0;
         instr_q  <= '0;
         npc_q    <= '0;
         wdat_q   <= '0;
         wsel_q   <= '0;
         rf_wen_q <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lbuf_q   <= lbuf_d;
         instr_q  <= instr_d;
         npc_q    <= npc_d;
         wdat_q   <= wdat_d;
         wsel_q   <= wsel_d;
         rf_wen_q <= rf_wen_d;
         halt_q   <= halt_d;
      end
   end

   assign instr_o    = instr_q;
   assign pipe_npc_o = npc_q;
   assign wdat_o     = wdat_q;
   assign wsel_o     = wsel_q;
   assign rfWEN_o    = rf_wen_q;
   assign halt_o     = halt_q;

`ifdef MEM_STALL_CNT_EN
   logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Count cycles stalled by an outstanding access, saturating; only reset clears it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (req && !dhit && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // Stall counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios with literal expectations, then randomized traffic.
// Every cycle's outputs are checked against a transaction-level model of the stage.
module tb_mem_wb_stage;

   logic        CLK, nRST;
   logic [31:0] instr_i, pipe_npc_i, aluout_i, rdat2_i, dmemload;
   logic [1:0]  rfInSel_i;
   logic [4:0]  wsel_i;
   logic        rfWEN_i, dREN_i, dWEN_i, halt_i, wb_en, flush, dhit;
   logic        dmemREN, dmemWEN, mem_stall, rfWEN_o, halt_o;
   logic [31:0] dmemaddr, dmemstore, instr_o, pipe_npc_o, wdat_o;
   logic [4:0]  wsel_o;
`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   mem_wb_stage dut (
      .CLK(CLK), .nRST(nRST),
      .instr_i(instr_i), .pipe_npc_i(pipe_npc_i), .aluout_i(aluout_i), .rdat2_i(rdat2_i),
      .rfInSel_i(rfInSel_i), .wsel_i(wsel_i), .rfWEN_i(rfWEN_i), .dREN_i(dREN_i),
      .dWEN_i(dWEN_i), .halt_i(halt_i), .wb_en(wb_en), .flush(flush), .dhit(dhit),
      .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall), .instr_o(instr_o),
      .pipe_npc_o(pipe_npc_o), .wdat_o(wdat_o), .wsel_o(wsel_o), .rfWEN_o(rfWEN_o),
      .halt_o(halt_o)
`ifdef MEM_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // held: a load's data arrived while writeback could not advance and is parked in m_lbuf.
   logic        m_held, m_consumed;
   logic [31:0] m_lbuf, m_instr, m_npc, m_wdat;
   logic [4:0]  m_wsel;
   logic        m_rfwen, m_halt;
`ifdef MEM_STALL_CNT_EN
   logic [31:0] m_cnt;
`endif
   logic        e_req, e_stall, e_ren, e_wen;
   logic [31:0] e_wd;

   always_comb begin
      e_req   = (dREN_i || dWEN_i) && !m_held && nRST;
      e_wen   = e_req && dWEN_i;
      e_ren   = e_req && !dWEN_i;
      e_stall = (e_req && !dhit) || !wb_en;
      if (rfInSel_i == 2'd1)      e_wd = m_held ? m_lbuf : dmemload;
      else if (rfInSel_i == 2'd2) e_wd = pipe_npc_i;
      else                        e_wd = aluout_i;
   end

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_held <= 1'b0; m_lbuf <= '0; m_instr <= '0; m_npc <= '0; m_wdat <= '0;
         m_wsel <= '0; m_rfwen <= 1'b0; m_halt <= 1'b0; m_consumed <= 1'b1;
`ifdef MEM_STALL_CNT_EN
         m_cnt <= '0;
`endif
      end else begin
         if (flush) begin
            m_instr <= '0; m_npc <= '0; m_wdat <= '0; m_wsel <= '0; m_rfwen <= 1'b0;
            m_held <= 1'b0; m_consumed <= 1'b1;
         end else if (wb_en && !e_stall) begin
            m_instr <= instr_i; m_npc <= pipe_npc_i; m_wdat <= e_wd; m_wsel <= wsel_i;
            m_rfwen <= rfWEN_i && (wsel_i != 5'd0); m_halt <= m_halt || halt_i;
            m_held <= 1'b0; m_consumed <= 1'b1;
         end else begin
            m_consumed <= 1'b0;
            if (wb_en) begin
               m_instr <= '0; m_rfwen <= 1'b0;
            end
            if (e_req && dhit && !wb_en) begin
               m_held <= 1'b1; m_lbuf <= dmemload;
            end
         end
`ifdef MEM_STALL_CNT_EN
         if (e_req && !dhit && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
`endif
      end
   end

   // One compare process: all outputs against the model, away from the active edge.
   always @(negedge CLK) begin
      if (run_cmp) begin
         check("dmemREN",    64'(dmemREN),    64'(e_ren));
         check("dmemWEN",    64'(dmemWEN),    64'(e_wen));
         check("dmemaddr",   64'(dmemaddr),   64'(aluout_i));
         check("dmemstore",  64'(dmemstore),  64'(rdat2_i));
         check("mem_stall",  64'(mem_stall),  64'(e_stall));
         check("instr_o",    64'(instr_o),    64'(m_instr));
         check("pipe_npc_o", 64'(pipe_npc_o), 64'(m_npc));
         check("wdat_o",     64'(wdat_o),     64'(m_wdat));
         check("wsel_o",     64'(wsel_o),     64'(m_wsel));
         check("rfWEN_o",    64'(rfWEN_o),    64'(m_rfwen));
         check("halt_o",     64'(halt_o),     64'(m_halt));
`ifdef MEM_STALL_CNT_EN
         check("stall_cnt",  64'(stall_cnt),  64'(m_cnt));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      instr_i = '0; pipe_npc_i = '0; aluout_i = '0; rdat2_i = '0; dmemload = '0;
      rfInSel_i = 2'd0; wsel_i = 5'd0; rfWEN_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0;
      halt_i = 1'b0; wb_en = 1'b1; flush = 1'b0; dhit = 1'b0;
   endtask

   task automatic new_instr();
      int r;
      instr_i    = $urandom;
      pipe_npc_i = $urandom;
      aluout_i   = $urandom;
      rdat2_i    = $urandom;
      rfInSel_i  = 2'($urandom_range(0, 3));
      wsel_i     = 5'($urandom_range(0, 7));
      rfWEN_i    = 1'($urandom_range(0, 1));
      r          = int'($urandom_range(0, 9));
      dREN_i     = (r < 3) || (r == 5);
      dWEN_i     = (r >= 3) && (r <= 5);
      halt_i     = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      nRST = 1'b0;
      idle_inputs();
      run_cmp = 1'b1;
      repeat (2) cyc();
      nRST = 1'b1;

      // reset state
      check("rst instr_o", 64'(instr_o), 64'h0);
      check("rst wdat_o",  64'(wdat_o),  64'h0);
      check("rst rfWEN_o", 64'(rfWEN_o), 64'h0);
      check("rst halt_o",  64'(halt_o),  64'h0);

      // ALU op: one-cycle latency, no stall
      instr_i = 32'h0011_8193; pipe_npc_i = 32'h104; aluout_i = 32'h1234;
      rfInSel_i = 2'd0; wsel_i = 5'd3; rfWEN_i = 1'b1;
      #1 check("alu stall", 64'(mem_stall), 64'h0);
      cyc();
      check("alu wdat", 64'(wdat_o), 64'h1234);
      check("alu wsel", 64'(wsel_o), 64'd3);
      check("alu wen",  64'(rfWEN_o), 64'h1);

      // load missing for 3 cycles: stall + bubbles, then data
      idle_inputs();
      instr_i = 32'h0000_2283; aluout_i = 32'h40; dREN_i = 1'b1; rfInSel_i = 2'd1;
      wsel_i = 5'd5; rfWEN_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("lw stall", 64'(mem_stall), 64'h1);
         check("lw ren",   64'(dmemREN),   64'h1);
         cyc();
         check("lw bubble wen",   64'(rfWEN_o), 64'h0);
         check("lw bubble instr", 64'(instr_o), 64'h0);
      end
      dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
      #1 check("lw hit stall", 64'(mem_stall), 64'h0);
      cyc();
      check("lw wdat", 64'(wdat_o), 64'hDEAD_BEEF);
      check("lw wen",  64'(rfWEN_o), 64'h1);
      check("lw wsel", 64'(wsel_o), 64'd5);
`ifdef MEM_STALL_CNT_EN
      check("lw stall_cnt", 64'(stall_cnt), 64'd3);
`endif

      // store: strobes until dhit, never writes the register file
      idle_inputs();
      dWEN_i = 1'b1; aluout_i = 32'h80; rdat2_i = 32'h55; wsel_i = 5'd7;
      #1;
      check("sw wen",   64'(dmemWEN),   64'h1);
      check("sw ren",   64'(dmemREN),   64'h0);
      check("sw addr",  64'(dmemaddr),  64'h80);
      check("sw store", 64'(dmemstore), 64'h55);
      cyc();
      dhit = 1'b1;
      #1 check("sw wen hit", 64'(dmemWEN), 64'h1);
      cyc();
      check("sw rfwen", 64'(rfWEN_o), 64'h0);

      // load hits while writeback is frozen: parked, no re-request, released later
      idle_inputs();
      dREN_i = 1'b1; rfInSel_i = 2'd1; wsel_i = 5'd9; rfWEN_i = 1'b1; aluout_i = 32'h44;
      dhit = 1'b1; dmemload = 32'hCAFE_F00D; wb_en = 1'b0;
      cyc();
      dhit = 1'b0; dmemload = 32'h1111_1111;
      #1;
      check("held ren",   64'(dmemREN),   64'h0);
      check("held stall", 64'(mem_stall), 64'h1);
      cyc();
      wb_en = 1'b1;
      #1 check("held release stall", 64'(mem_stall), 64'h0);
      cyc();
      check("held wdat", 64'(wdat_o), 64'hCAFE_F00D);
      check("held wsel", 64'(wsel_o), 64'd9);
`ifdef MEM_STALL_CNT_EN
      check("held stall_cnt", 64'(stall_cnt), 64'd4);
`endif

      // sticky halt survives flush, cleared by reset
      idle_inputs();
      halt_i = 1'b1; aluout_i = 32'h1; wsel_i = 5'd2; rfWEN_i = 1'b1;
      cyc();
      check("halt set", 64'(halt_o), 64'h1);
      idle_inputs();
      flush = 1'b1; aluout_i = 32'h2; wsel_i = 5'd4; rfWEN_i = 1'b1;
      cyc();
      check("flush halt",  64'(halt_o),  64'h1);
      check("flush rfwen", 64'(rfWEN_o), 64'h0);
      check("flush wdat",  64'(wdat_o),  64'h0);
      idle_inputs();
      nRST = 1'b0;
      #1 check("reset halt", 64'(halt_o), 64'h0);
      cyc();
      nRST = 1'b1;

      // jal selects npc; wsel 0 never writes
      rfInSel_i = 2'd2; pipe_npc_i = 32'h404; aluout_i = 32'h999; wsel_i = 5'd31;
      rfWEN_i = 1'b1;
      cyc();
      check("jal wdat", 64'(wdat_o), 64'h404);
      check("jal wsel", 64'(wsel_o), 64'd31);
      check("jal wen",  64'(rfWEN_o), 64'h1);
      wsel_i = 5'd0;
      cyc();
      check("x0 wen", 64'(rfWEN_o), 64'h0);

      // reset in the middle of an access, then a stray hit
      idle_inputs();
      dREN_i = 1'b1; rfInSel_i = 2'd1; wsel_i = 5'd6; rfWEN_i = 1'b1;
      cyc();
      nRST = 1'b0;
      #1 check("rst mid ren", 64'(dmemREN), 64'h0);
      cyc();
      idle_inputs();
      nRST = 1'b1;
      dhit = 1'b1; dmemload = 32'h7777_7777; aluout_i = 32'h10; wsel_i = 5'd1;
      cyc();
      check("stray hit wdat", 64'(wdat_o), 64'h10);
      dhit = 1'b0;

      // randomized traffic; the upstream presents a new instruction once the model retires one
      for (int n = 0; n < 3000; n++) begin
         if (!nRST) begin
            nRST = 1'b1;
         end else if ($urandom_range(0, 299) == 0) begin
            nRST = 1'b0;
         end
         if (m_consumed) new_instr();
         wb_en    = ($urandom_range(0, 4) != 0);
         flush    = ($urandom_range(0, 24) == 0);
         dhit     = ($urandom_range(0, 9) < 3);
         dmemload = $urandom;
         cyc();
      end

      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
